// File: rtl/cpu_int_pkg.sv
// Shared interrupt-controller types and sizes.
package cpu_int_pkg;

    localparam int NUM_IRQ = 4;
    localparam int ID_W    = 2;

    typedef enum logic {
        IDLE    = 1'b0,
        SERVICE = 1'b1
    } int_state_t;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: lowest-index set bit wins.
module irq_prio_enc
    import cpu_int_pkg::*;
(
    input  logic [NUM_IRQ-1:0] eligible,
    output logic [ID_W-1:0]    sel,
    output logic               any
);

    always_comb begin
        sel = '0;
        any = |eligible;
        // Scanning downward lets the lowest set bit overwrite the others.
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (eligible[i]) sel = ID_W'(i);
        end
    end

endmodule

// File: rtl/int_req_ctrl.sv
// Interrupt request controller: edge-captured pending bits, priority take,
// single-level service until eret.
//
// state   | meaning
// IDLE    | may take an eligible request at a retiring instruction
// SERVICE | handler running; new requests only accumulate until eret
module int_req_ctrl
    import cpu_int_pkg::*;
#(
    parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
    parameter logic [31:0] VEC_STRIDE = 32'd16
) (
    input  logic        in_CLK,
    input  logic        in_RST_N,
    input  logic [3:0]  in_IRQ,
    input  logic        in_IE,
    input  logic [3:0]  in_INM,
    input  logic        in_WB_VALID,
    input  logic        in_ERET,
    output logic        out_BK,
    output logic        out_NIE,
    output logic [31:0] out_VECTOR,
    output logic [3:0]  out_PEND,
    output logic [1:0]  out_ACT_ID,
    output logic        out_BUSY
);

    int_state_t         state;
    logic [NUM_IRQ-1:0] irq_q;
    logic [NUM_IRQ-1:0] pend;
    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] eligible;
    logic [NUM_IRQ-1:0] take_mask;
    logic [ID_W-1:0]    sel;
    logic               any;

    irq_prio_enc u_prio_enc (
        .eligible (eligible),
        .sel      (sel),
        .any      (any)
    );

    assign rise      = in_IRQ & ~irq_q;
    assign eligible  = pend & ~in_INM;
    assign out_BK    = (state == IDLE) & in_IE & in_WB_VALID & any;
    assign out_NIE   = ~out_BK;
    assign take_mask = out_BK ? (NUM_IRQ'(1) << sel) : '0;

    assign out_VECTOR = VEC_BASE + VEC_STRIDE * {{(32 - ID_W){1'b0}}, sel};
    assign out_PEND   = pend;
    assign out_BUSY   = (state == SERVICE);

    always_ff @(posedge in_CLK) begin
        if (!in_RST_N) begin
            state      <= IDLE;
            pend       <= '0;
            out_ACT_ID <= '0;
            // Treat every line as already high so a line held through reset
            // does not look like a fresh request.
            irq_q      <= '1;
        end else begin
            irq_q <= in_IRQ;
            // A new edge on the line being taken keeps its pending bit set.
            pend  <= (pend & ~take_mask) | rise;
            if (state == IDLE) begin
                if (out_BK) begin
                    state      <= SERVICE;
                    out_ACT_ID <= sel;
                end
            end else begin
                if (in_ERET) state <= IDLE;
            end
        end
    end

endmodule
